// File: rtl/mac_pkg.sv
// Shared types and constants for the serial spike-gated MAC and its FP32 adder.
package mac_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned FP_W     = 1 + EXP_W + MANT_W;

  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [FP_W-1:0]  QNAN     = 32'h7FC0_0000;
  localparam logic [FP_W-1:0]  POS_ZERO = 32'h0000_0000;

  // FSM state encoding
  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_ACC  = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_ACC  = ENC_ACC,
    ST_DONE = ENC_DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single-precision adder: RNE rounding, subnormals
// flushed to +0, canonical quiet NaN, exact cancellation yields +0.
module fp32_add
  import mac_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  // Significand datapath: carry + hidden + mantissa + guard/round/sticky
  localparam int unsigned SIG_W = MANT_W + 1;
  localparam int unsigned EXT_W = SIG_W + 4;

  fp32_t              fa, fb, big, sml;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0]   d;
  logic [EXT_W-1:0]   sig_b, sig_s, sig_al, mask, raw;
  logic               sticky;
  logic [EXT_W-2:0]   norm;
  logic [4:0]         lz;
  logic signed [9:0]  e_r;
  logic               rnd_up;
  logic [SIG_W:0]     mant_r;
  logic [MANT_W-1:0]  frac;
  logic [31:0]        res_norm;

  // Classify, align, add/subtract, normalise, round, then pick special cases
  always_comb begin
    fa = fp32_t'(a);
    fb = fp32_t'(b);
    a_nan  = (fa.expo == EXP_MAX) && (fa.mant != '0);
    b_nan  = (fb.expo == EXP_MAX) && (fb.mant != '0);
    a_inf  = (fa.expo == EXP_MAX) && (fa.mant == '0);
    b_inf  = (fb.expo == EXP_MAX) && (fb.mant == '0);
    a_zero = (fa.expo == '0);
    b_zero = (fb.expo == '0);

    // Larger magnitude operand sets exponent and sign
    if ({fa.expo, fa.mant} >= {fb.expo, fb.mant}) begin
      big = fa;
      sml = fb;
    end else begin
      big = fb;
      sml = fa;
    end
    d     = big.expo - sml.expo;
    sig_b = {1'b0, 1'b1, big.mant, 3'b000};
    sig_s = {1'b0, 1'b1, sml.mant, 3'b000};

    if (d >= EXP_W'(EXT_W)) begin
      mask   = '0;
      sig_al = '0;
      sticky = 1'b1;
    end else begin
      mask   = (EXT_W'(1) << d) - EXT_W'(1);
      sticky = |(sig_s & mask);
      sig_al = sig_s >> d;
    end
    sig_al[0] = sig_al[0] | sticky;

    raw = (big.sign == sml.sign) ? (sig_b + sig_al) : (sig_b - sig_al);

    // Normalise so the hidden bit lands at the top of norm
    e_r = $signed({2'b00, big.expo});
    lz  = '0;
    if (raw[EXT_W-1]) begin
      norm = {raw[EXT_W-1:2], raw[1] | raw[0]};
      e_r  = e_r + 10'sd1;
    end else begin
      for (int i = 0; i < int'(EXT_W) - 1; i++) begin
        if (raw[i]) lz = 5'(int'(EXT_W) - 2 - i);
      end
      norm = raw[EXT_W-2:0] << lz;
      e_r  = e_r - $signed({5'b00000, lz});
    end

    // Round to nearest, ties to even
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[EXT_W-2:3]} + (SIG_W+1)'(rnd_up);
    if (mant_r[SIG_W]) begin
      e_r  = e_r + 10'sd1;
      frac = mant_r[SIG_W-1:1];
    end else begin
      frac = mant_r[MANT_W-1:0];
    end

    if (raw == '0)             res_norm = POS_ZERO;
    else if (e_r >= 10'sd255)  res_norm = {big.sign, EXP_MAX, {MANT_W{1'b0}}};
    else if (e_r <= 10'sd0)    res_norm = POS_ZERO;
    else                       res_norm = {big.sign, e_r[EXP_W-1:0], frac};

    if (a_nan || b_nan)                         sum = QNAN;
    else if (a_inf && b_inf && (fa.sign != fb.sign)) sum = QNAN;
    else if (a_inf)                             sum = a;
    else if (b_inf)                             sum = b;
    else if (a_zero && b_zero)                  sum = POS_ZERO;
    else if (a_zero)                            sum = b;
    else if (b_zero)                            sum = a;
    else                                        sum = res_norm;
  end

endmodule

// File: rtl/mac_serial.sv
// Serial spike-gated MAC: captures a spike vector and FP32 weights, then
// scans one channel per cycle through a shared adder into an accumulator.
module mac_serial
  import mac_pkg::*;
#(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned IDX_W    = $clog2(N_INPUTS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     acc_mode,
  input  logic [N_INPUTS-1:0]      spike_in,
  input  logic [32*N_INPUTS-1:0]   weights_in,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              result
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [31:0]           acc_q, acc_d;
  logic [N_INPUTS-1:0]   spk_q, spk_d;
  logic [31:0]           w_q [N_INPUTS];
  logic [31:0]           w_d [N_INPUTS];
  logic [31:0]           result_q, result_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [31:0]           add_sum;

  fp32_add u_add (
    .a   (acc_q),
    .b   (w_q[idx_q]),
    .sum (add_sum)
  );

  // Next-state and datapath updates; start only honoured in idle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    spk_d    = spk_q;
    w_d      = w_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          spk_d = spike_in;
          for (int i = 0; i < int'(N_INPUTS); i++) w_d[i] = weights_in[32*i +: 32];
          acc_d   = acc_mode ? result_q : POS_ZERO;
          idx_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (spk_q[idx_q]) acc_d = add_sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= POS_ZERO;
      spk_q    <= '0;
      for (int i = 0; i < int'(N_INPUTS); i++) w_q[i] <= '0;
      result_q <= POS_ZERO;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      spk_q    <= spk_d;
      w_q      <= w_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mac_serial.sv
// Bench for mac_serial: vector table plus hand-written control sequences,
// with a result scoreboard checked on every done pulse.
module tb_mac_serial;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         start;
  logic         acc_mode;
  logic [3:0]   spike_in;
  logic [127:0] weights_in;
  logic         busy;
  logic         done;
  logic [31:0]  result;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] sb_e;

  localparam logic [127:0] W_STD = {32'h3DCCCCCD, 32'h40000000, 32'h3F99999A, 32'h40400000};

  typedef struct {
    logic [3:0]   spk;
    logic         mode;
    logic [127:0] w;
    logic [31:0]  res;
  } vec_t;

  vec_t vecs [14];

  mac_serial #(.N_INPUTS(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .acc_mode   (acc_mode),
    .spike_in   (spike_in),
    .weights_in (weights_in),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: each done pulse consumes the oldest expected result
  always @(posedge CLK) begin
    #1;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", result, 32'hxxxxxxxx);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_result", result, sb_e);
      end
    end
  end

  // Drive one start at a negedge; returns #1 after the capture edge
  task automatic start_op(input logic [3:0] spk, input logic mode,
                          input logic [127:0] w, input logic [31:0] e);
    @(negedge CLK);
    spike_in   = spk;
    acc_mode   = mode;
    weights_in = w;
    start      = 1'b1;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    start      = 1'b0;
    spike_in   = 4'($urandom);
    weights_in = {$urandom, $urandom, $urandom, $urandom};
    acc_mode   = 1'($urandom);
    chk("busy_at_capture", 32'(busy), 32'd1);
  endtask

  // Wait for done; 'already' edges since capture have been consumed
  task automatic wait_done(input int already);
    int n;
    n = already;
    while (n < 20) begin
      @(posedge CLK);
      #1;
      n++;
      if (done) break;
      chk("busy_running", 32'(busy), 32'd1);
    end
    chk("latency", 32'(n), 32'd5);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int first_done, second_done, dc;

    vecs[0]  = '{4'b0001, 1'b0, W_STD, 32'h40400000};
    vecs[1]  = '{4'b0000, 1'b0, W_STD, 32'h00000000};
    vecs[2]  = '{4'b1111, 1'b0, W_STD, 32'h40C99999};
    vecs[3]  = '{4'b0001, 1'b0, W_STD, 32'h40400000};
    vecs[4]  = '{4'b0001, 1'b1, W_STD, 32'h40C00000};
    vecs[5]  = '{4'b0000, 1'b1, W_STD, 32'h40C00000};
    vecs[6]  = '{4'b0011, 1'b0, {64'h0, 32'hC0000000, 32'h40000000}, 32'h00000000};
    vecs[7]  = '{4'b0011, 1'b0, {64'h0, 32'hFF800000, 32'h7F800000}, 32'h7FC00000};
    vecs[8]  = '{4'b0110, 1'b0, W_STD, 32'h404CCCCD};
    vecs[9]  = '{4'b1000, 1'b0, W_STD, 32'h3DCCCCCD};
    vecs[10] = '{4'b0011, 1'b0, {64'h0, 32'h7F7FFFFF, 32'h7F7FFFFF}, 32'h7F800000};
    vecs[11] = '{4'b0001, 1'b0, {96'h0, 32'h7F800001}, 32'h7FC00000};
    vecs[12] = '{4'b0001, 1'b0, {96'h0, 32'h00000001}, 32'h00000000};
    vecs[13] = '{4'b0011, 1'b0, {64'h0, 32'h3F99999A, 32'hC0400000}, 32'hBFE66666};

    RESET = 1'b0;
    start = 1'b0;
    acc_mode = 1'b0;
    spike_in = '0;
    weights_in = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].spk, vecs[i].mode, vecs[i].w, vecs[i].res);
      wait_done(0);
    end

    // Second start two edges into a run must be ignored
    dc = done_cnt;
    start_op(4'b0001, 1'b0, W_STD, 32'h40400000);
    @(negedge CLK);
    @(negedge CLK);
    start = 1'b1;
    spike_in = 4'b1111;
    weights_in = W_STD;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(2);
    repeat (8) @(posedge CLK);
    #1;
    chk("glitch_one_done", 32'(done_cnt - dc), 32'd1);

    // Reset mid-accumulation discards the run
    start_op(4'b1111, 1'b0, W_STD, 32'h40C99999);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    void'(exp_q.pop_back());
    dc = done_cnt;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    start_op(4'b0001, 1'b1, W_STD, 32'h40400000);
    wait_done(0);

    // Start held high through DONE is accepted on the first idle edge
    @(negedge CLK);
    spike_in = 4'b0001;
    acc_mode = 1'b1;
    weights_in = W_STD;
    start = 1'b1;
    exp_q.push_back(32'h40C00000);
    exp_q.push_back(32'h41100000);
    @(posedge CLK);
    #1;
    first_done = 0;
    second_done = 0;
    for (int c = 1; c <= 30 && second_done == 0; c++) begin
      @(posedge CLK);
      #1;
      if (c == 6) start = 1'b0;
      if (done) begin
        if (first_done == 0) first_done = c;
        else second_done = c;
      end
    end
    chk("b2b_first_lat", 32'(first_done), 32'd5);
    chk("b2b_second_lat", 32'(second_done), 32'd11);

    repeat (8) @(posedge CLK);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("result_stable", result, 32'h41100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
